synth_step_sequencer: RTL
=========================

// Module: synth_step_sequencer
// PURPOSE
//   Step sequencer and envelope controller for the Synth voice. It plays a 16-step note pattern at a fixed
//   step rate and drives Synth's gate, phase increment and amplitude. It also exports a one-hot step
//   vector for the LED16 matrix. The SAMD51 programs the pattern over the SPI-decoded cfg write port.
// PARAMETERS
//   CLKSPEED   48_000_000  system clock in Hz (SB_HFOSC)
//   STEP_HZ    8           steps per second; STEP_DIV = CLKSPEED/STEP_HZ clocks per step
//   STEPS      16          pattern length (power of 2); pointer width SW = $clog2(STEPS)
//   INC_W      24          phase-increment width per pattern entry
//   AMP_W      10          amplitude width (matches Synth amp_in)
//   ENV_DIV    4096        clocks per envelope update tick
//   ATK_STEP   8           amplitude added per envelope tick in ATTACK
//   REL_STEP   4           amplitude removed per envelope tick in RELEASE
// PORTS
//   clk        in   1        system clock
//   rst_n      in   1        asynchronous reset, active low
//   run        in   1        1 = sequencer advancing; 0 = stopped
//   amp_max    in   AMP_W    sustain level / attack ceiling
//   cfg_we     in   1        pattern write strobe (single cycle, always accepted)
//   cfg_addr   in   SW       pattern entry index
//   cfg_data   in   INC_W+1  {rest, phase_inc}; rest=1 means silent step
//   gate       out  1        note-on to Synth
//   phase_inc  out  INC_W    oscillator increment to Synth
//   amp        out  AMP_W    envelope amplitude to Synth amp_in
//   step_oh    out  STEPS    one-hot of last played step (to LED16 ledbits)
//   step_tick  out  1        1-cycle pulse when a step is launched
// BEHAVIOUR
//   Reset: gate=0, phase_inc=0, amp=0, step_oh=0, step_tick=0, ptr=0, env=IDLE, counters=0.
//   Pattern: STEPS x (INC_W+1) register array, reset to all-zero (rest=0, inc=0).
//   Step timer: increments while run=1. It wraps at STEP_DIV-1 and pulses tick on the wrap. run=0 holds it at 0.
//   On tick (cycle T): read entry[ptr], then ptr<=ptr+1 (wraps STEPS-1->0). At T+1: step_tick=1 and step_oh=1<<old ptr.
//     rest=0: phase_inc<=inc, gate<=1, env->ATTACK. rest=1: gate<=0, phase_inc held, env->RELEASE (IDLE stays IDLE).
//   Gate length: gate drops (env->RELEASE) when the step timer reaches STEP_DIV/2 within a gated step.
//   Write vs read collision: cfg_we with cfg_addr==ptr in the tick cycle is write-first, so cfg_data is played.
//   Envelope FSM (updates on env_tick, every ENV_DIV clocks, free-running):
//     IDLE   : amp=0; leave only via a note tick -> ATTACK
//     ATTACK : amp += ATK_STEP, saturating at amp_max; on reaching amp_max -> SUSTAIN
//     SUSTAIN: amp tracks amp_max (clamped down or raised to it on the next env_tick); gate drop -> RELEASE
//     RELEASE: amp -= REL_STEP, saturating at 0; on reaching 0 -> IDLE
//   Retrigger: a note tick in any state -> ATTACK, starting from the current amp (no reset to 0, no click).
//     If amp >= amp_max, go directly to SUSTAIN.
//   Arithmetic: AMP_W+1-bit intermediate for add/sub, then saturate; amp never exceeds amp_max or wraps.
//   run falling: timer cleared, ptr held; env forced to RELEASE unless IDLE; gate<=0 next cycle.
//   run rising: first tick after a full STEP_DIV and plays entry[ptr].
//   Simultaneous gate-drop and note tick: the note tick wins (ATTACK, gate=1).
//   Mid-operation reset: everything returns to reset values asynchronously. Pattern contents are also cleared.
// STRUCTURE
//   synth_pkg: env_state_t {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE}, pattern entry field widths
//     and REST_BIT index.
//   Sub-module seq_envelope: envelope FSM plus ENV_DIV prescaler.
//     Inputs: note_on, note_off, amp_max. Output: amp.
//   Top level holds the step timer, pointer, pattern array and cfg port.
// TESTING  (bench: CLKSPEED=1600, STEP_HZ=100 -> STEP_DIV=16, ENV_DIV=1, ATK_STEP=8, REL_STEP=4)
//   Reset held, outputs sampled -> gate=0, amp=0, phase_inc=0, step_oh=0; release rst_n, run=0 for 100 clk
//     -> no step_tick.
//   Write entries 0..3 = 0x000100, 0x000200, rest, 0x000400; run=1, amp_max=64.
//     -> step_tick every 16 clk; phase_inc 0x100, 0x200 (held), 0x400; step_oh 0x1, 0x2, 0x4, 0x8; gate low on step 2.
//   Envelope: note at amp=0, amp_max=64 -> amp 8,16,...,64 over 8 clk then SUSTAIN.
//     Gate drops at clk 8 of step -> amp falls by 4 per clk to 0 -> IDLE.
//   Retrigger mid-RELEASE at amp=40 -> amp 48 next env tick (no drop to 0).
//     Lower amp_max to 20 during SUSTAIN -> amp=20 next tick.
//   cfg_we to addr==ptr in the tick cycle with 0x000777 -> phase_inc=0x777.
//     ptr wraps 15->0 and step_oh goes 0x8000 -> 0x0001.
//   Deassert run mid-SUSTAIN -> gate=0 next clk, amp ramps to 0.
//     Assert rst_n=0 mid-ATTACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and default widths for the Synth step sequencer and its envelope.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package synth_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    localparam int DEF_INC_W = 24;
    localparam int DEF_AMP_W = 10;
    localparam int ENTRY_W   = DEF_INC_W + 1;
    localparam int REST_BIT  = DEF_INC_W;

endpackage

// File: rtl/seq_envelope.sv
// Envelope FSM (idle/attack/sustain/release) with a free-running ENV_DIV prescaler.
// Latency: note events change state on the next clk; amp moves one step per env tick.
// Backpressure: none; note_on/note_off are single-cycle strobes, always accepted.
module seq_envelope
    import synth_pkg::*;
#(
    parameter int AMP_W    = DEF_AMP_W,
    parameter int ENV_DIV  = 4096,
    parameter int ATK_STEP = 8,
    parameter int REL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_on,
    input  logic             note_off,
    input  logic [AMP_W-1:0] amp_max,
    output logic [AMP_W-1:0] amp
);

    localparam int DW  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam int AW1 = AMP_W + 1;

    env_state_t     state, state_nxt;
    logic [AMP_W-1:0] amp_nxt;
    logic [DW-1:0]  div_cnt;
    logic           env_tick;
    logic [AW1-1:0] sum, diff;

    assign env_tick = (div_cnt == DW'(ENV_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            state   <= ENV_IDLE;
            amp     <= '0;
        end else begin
            div_cnt <= env_tick ? '0 : div_cnt + DW'(1);
            state   <= state_nxt;
            amp     <= amp_nxt;
        end
    end

    // Note events only move the state; amp keeps its value so a retrigger never clicks.
    always_comb begin
        state_nxt = state;
        amp_nxt   = amp;
        sum       = {1'b0, amp} + AW1'(ATK_STEP);
        diff      = {1'b0, amp} - AW1'(REL_STEP);
        if (note_on) begin
            state_nxt = (amp >= amp_max) ? ENV_SUSTAIN : ENV_ATTACK;
        end else if (note_off && state != ENV_IDLE) begin
            state_nxt = ENV_RELEASE;
        end else if (env_tick) begin
            case (state)
                ENV_IDLE: amp_nxt = '0;
                ENV_ATTACK: begin
                    if (sum >= {1'b0, amp_max}) begin
                        amp_nxt   = amp_max;
                        state_nxt = ENV_SUSTAIN;
                    end else begin
                        amp_nxt = sum[AMP_W-1:0];
                    end
                end
                ENV_SUSTAIN: amp_nxt = amp_max;
                ENV_RELEASE: begin
                    if (diff[AMP_W] || diff == '0) begin
                        amp_nxt   = '0;
                        state_nxt = ENV_IDLE;
                    end else begin
                        amp_nxt = diff[AMP_W-1:0];
                    end
                end
                default: state_nxt = ENV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/synth_step_sequencer.sv
// 16-step note sequencer driving Synth gate/phase_inc/amp plus a one-hot LED step vector.
// Latency: step outputs update 1 clk after the internal step tick; envelope per env tick.
// Backpressure: none; cfg writes are single-cycle and always accepted.
module synth_step_sequencer
    import synth_pkg::*;
#(
    parameter int CLKSPEED = 48_000_000,
    parameter int STEP_HZ  = 8,
    parameter int STEPS    = 16,
    parameter int INC_W    = DEF_INC_W,
    parameter int AMP_W    = DEF_AMP_W,
    parameter int ENV_DIV  = 4096,
    parameter int ATK_STEP = 8,
    parameter int REL_STEP = 4,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [AMP_W-1:0] amp_max,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_addr,
    input  logic [INC_W:0]   cfg_data,
    output logic             gate,
    output logic [INC_W-1:0] phase_inc,
    output logic [AMP_W-1:0] amp,
    output logic [STEPS-1:0] step_oh,
    output logic             step_tick
);

    localparam int STEP_DIV = CLKSPEED / STEP_HZ;
    localparam int CW       = $clog2(STEP_DIV);

    logic [INC_W:0]  pattern [STEPS];
    logic [INC_W:0]  entry;
    logic [CW-1:0]   step_cnt;
    logic [SW-1:0]   ptr;
    logic            run_q;
    logic            tick, gate_drop, run_fall, entry_rest;
    logic            note_on, note_off;

    assign tick       = run && (step_cnt == CW'(STEP_DIV - 1));
    // Write-first: a write to the entry being launched this cycle is what gets played.
    assign entry      = (cfg_we && cfg_addr == ptr) ? cfg_data : pattern[ptr];
    assign entry_rest = entry[INC_W];
    assign gate_drop  = run && gate && (step_cnt == CW'(STEP_DIV / 2));
    assign run_fall   = run_q && !run;
    assign note_on    = tick && !entry_rest;
    assign note_off   = (tick && entry_rest) || (gate_drop && !tick) || run_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
        end else if (cfg_we) begin
            pattern[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt  <= '0;
            ptr       <= '0;
            run_q     <= 1'b0;
            gate      <= 1'b0;
            phase_inc <= '0;
            step_oh   <= '0;
            step_tick <= 1'b0;
        end else begin
            run_q     <= run;
            step_tick <= tick;
            if (!run || tick) step_cnt <= '0;
            else              step_cnt <= step_cnt + CW'(1);
            if (tick) begin
                ptr     <= ptr + SW'(1);
                step_oh <= {{(STEPS-1){1'b0}}, 1'b1} << ptr;
                if (!entry_rest) begin
                    phase_inc <= entry[INC_W-1:0];
                    gate      <= 1'b1;
                end else begin
                    gate      <= 1'b0;
                end
            end else if (!run || gate_drop) begin
                gate <= 1'b0;
            end
        end
    end

    seq_envelope #(
        .AMP_W    (AMP_W),
        .ENV_DIV  (ENV_DIV),
        .ATK_STEP (ATK_STEP),
        .REL_STEP (REL_STEP)
    ) u_env (
        .clk      (clk),
        .rst_n    (rst_n),
        .note_on  (note_on),
        .note_off (note_off),
        .amp_max  (amp_max),
        .amp      (amp)
    );

endmodule
